// File: rtl/frame_ingest_pkg.sv
// rtl/frame_ingest_pkg.sv - shared constants, record layout, parser states and CRC step for frame_ingest
package frame_ingest_pkg;

    localparam logic [15:0] SYNC_WORD = 16'hEB90;
    localparam logic [15:0] CRC_POLY  = 16'h1021;
    localparam logic [15:0] CRC_INIT  = 16'hFFFF;

    localparam int REC_W           = 140;
    localparam int PAYLOAD_W       = 128;
    localparam int REC_PAYLOAD_LSB = 0;
    localparam int REC_COUNT_LSB   = 128;
    localparam int REC_MASK_LSB    = 132;
    localparam int MAX_LEN         = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CTRL  = 2'd1,
        ST_DATA  = 2'd2,
        ST_CHECK = 2'd3
    } parse_state_e;

    // One 16-bit word through CRC-16/CCITT, MSB first, no reflection.
    function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic [15:0] word);
        logic [15:0] c;
        c = crc;
        for (int i = 15; i >= 0; i--) begin
            if (c[15] ^ word[i]) begin
                c = {c[14:0], 1'b0} ^ CRC_POLY;
            end else begin
                c = {c[14:0], 1'b0};
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/frame_ingest_crc16_word.sv
// rtl/frame_ingest_crc16_word.sv - word-serial CRC-16 engine with seed-on-first-word and done pulse
module crc16_word #(
    parameter logic [15:0] CRC_INIT = frame_ingest_pkg::CRC_INIT
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        valid_i,
    input  logic [15:0] data_i,
    output logic [15:0] crc_o,
    output logic        done_o
);
    import frame_ingest_pkg::*;

    logic [15:0] crc_q, crc_d;
    logic        valid_q;

    // A run of valid words starts from the seed; otherwise the register holds.
    always_comb begin
        crc_d = crc_q;
        if (valid_i) begin
            crc_d = crc16_step(valid_q ? crc_q : CRC_INIT, data_i);
        end
    end

    // CRC register and previous-valid flag.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            crc_q   <= CRC_INIT;
            valid_q <= 1'b0;
        end else begin
            crc_q   <= crc_d;
            valid_q <= valid_i;
        end
    end

    assign crc_o  = crc_q;
    assign done_o = valid_q & ~valid_i;

endmodule

// File: rtl/frame_ingest.sv
// rtl/frame_ingest.sv - frame parser with CRC check feeding a dual-clock record FIFO
module frame_ingest #(
    parameter logic [15:0] SYNC_WORD  = frame_ingest_pkg::SYNC_WORD,
    parameter int          FIFO_DEPTH = 8,
    parameter logic [15:0] CRC_INIT   = frame_ingest_pkg::CRC_INIT
) (
    input  logic                             clk_in,
    input  logic                             rst_n,
    input  logic                             clk_out,
    input  logic [15:0]                      data_in,
    input  logic                             fifo_r_enable,
    output logic [frame_ingest_pkg::REC_W-1:0] data_from_fifo,
    output logic                             fifo_full,
    output logic                             fifo_empty,
    output logic                             crc_err
);
    import frame_ingest_pkg::*;

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] FULL_XOR = PW'(3) << (PW - 2);

    // ---------------- parser ----------------
    parse_state_e state_q, state_d;
    logic [7:0]   mask_q;
    logic [3:0]   len_q;
    logic [2:0]   idx_q;
    logic [PAYLOAD_W-1:0] payload_q;
    logic         fifo_w_enable_q;
    logic         crc_err_q;

    logic         word_valid, ctrl_load, data_load, check_now;
    logic         len_ok, last_word;
    logic [15:0]  crc_val;
    logic         crc_done;

    assign len_ok    = (data_in[3:0] != 4'd0) && (data_in[3:0] <= 4'(MAX_LEN));
    assign last_word = (4'(idx_q) + 4'd1) == len_q;

    // Parser state register.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: the frame length fixes where CHECK lands, no header search inside a frame.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (data_in == SYNC_WORD) state_d = ST_CTRL;
            ST_CTRL:  state_d = len_ok ? ST_DATA : ST_IDLE;
            ST_DATA:  if (last_word) state_d = ST_CHECK;
            ST_CHECK: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Per-state strobes for the datapath and CRC engine.
    always_comb begin
        word_valid = 1'b0;
        ctrl_load  = 1'b0;
        data_load  = 1'b0;
        check_now  = 1'b0;
        case (state_q)
            ST_CTRL:  begin word_valid = 1'b1; ctrl_load = 1'b1; end
            ST_DATA:  begin word_valid = 1'b1; data_load = 1'b1; end
            ST_CHECK: check_now = 1'b1;
            default:  ;
        endcase
    end

    crc16_word #(.CRC_INIT(CRC_INIT)) u_crc (
        .clk_i   (clk_in),
        .rst_n_i (rst_n),
        .valid_i (word_valid),
        .data_i  (data_in),
        .crc_o   (crc_val),
        .done_o  (crc_done)
    );

    // Record capture and the one-cycle write / error pulses after the CRC word.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            mask_q          <= '0;
            len_q           <= '0;
            idx_q           <= '0;
            payload_q       <= '0;
            fifo_w_enable_q <= 1'b0;
            crc_err_q       <= 1'b0;
        end else begin
            if (ctrl_load) begin
                mask_q    <= data_in[15:8];
                len_q     <= data_in[3:0];
                idx_q     <= '0;
                payload_q <= '0;
            end
            if (data_load) begin
                payload_q[PAYLOAD_W - 1 - 16 * int'(idx_q) -: 16] <= data_in;
                idx_q <= idx_q + 3'd1;
            end
            fifo_w_enable_q <= check_now & crc_done & (data_in == crc_val);
            crc_err_q       <= check_now & crc_done & (data_in != crc_val);
        end
    end

    assign crc_err = crc_err_q;

    // ---------------- async FIFO ----------------
    logic [REC_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [REC_W-1:0] rec_w;
    logic [PW-1:0]    wbin_q, wgray_q, wbin_d, wgray_d;
    logic [PW-1:0]    rgray_s1_q, rgray_s2_q;
    logic [PW-1:0]    rbin_q, rgray_q, rbin_d, rgray_d;
    logic [PW-1:0]    wgray_s1_q, wgray_s2_q;
    logic [REC_W-1:0] data_q;
    logic             wr_do, rd_do;

    assign rec_w = {mask_q, len_q, payload_q};

    assign fifo_full = (wgray_q == (rgray_s2_q ^ FULL_XOR));
    assign wr_do     = fifo_w_enable_q & ~fifo_full;
    assign wbin_d    = wbin_q + PW'(wr_do);
    assign wgray_d   = wbin_d ^ (wbin_d >> 1);

    // Write pointers and read-pointer synchroniser in the clk_in domain.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            wbin_q     <= '0;
            wgray_q    <= '0;
            rgray_s1_q <= '0;
            rgray_s2_q <= '0;
        end else begin
            wbin_q     <= wbin_d;
            wgray_q    <= wgray_d;
            rgray_s1_q <= rgray_q;
            rgray_s2_q <= rgray_s1_q;
        end
    end

    // Record storage, written only when there is room.
    always_ff @(posedge clk_in) begin
        if (wr_do) begin
            fifo_mem[wbin_q[AW-1:0]] <= rec_w;
        end
    end

    assign fifo_empty = (rgray_q == wgray_s2_q);
    assign rd_do      = fifo_r_enable & ~fifo_empty;
    assign rbin_d     = rbin_q + PW'(rd_do);
    assign rgray_d    = rbin_d ^ (rbin_d >> 1);

    // Read pointers, write-pointer synchroniser and registered output in the clk_out domain.
    always_ff @(posedge clk_out or negedge rst_n) begin
        if (!rst_n) begin
            rbin_q     <= '0;
            rgray_q    <= '0;
            wgray_s1_q <= '0;
            wgray_s2_q <= '0;
            data_q     <= '0;
        end else begin
            rbin_q     <= rbin_d;
            rgray_q    <= rgray_d;
            wgray_s1_q <= wgray_q;
            wgray_s2_q <= wgray_s1_q;
            if (rd_do) begin
                data_q <= fifo_mem[rbin_q[AW-1:0]];
            end
        end
    end

    assign data_from_fifo = data_q;

endmodule

// File: tb/tb_frame_ingest.sv
// tb/tb_frame_ingest.sv - randomized scoreboard bench for frame_ingest
module tb_frame_ingest;

    localparam logic [15:0] SYNC  = 16'hEB90;
    localparam int          DEPTH = 8;

    logic         clk_in = 1'b0;
    logic         clk_out = 1'b0;
    logic         rst_n = 1'b0;
    logic [15:0]  data_in = 16'h0000;
    logic         fifo_r_enable = 1'b0;
    logic [139:0] data_from_fifo;
    logic         fifo_full, fifo_empty, crc_err;

    frame_ingest dut (
        .clk_in         (clk_in),
        .rst_n          (rst_n),
        .clk_out        (clk_out),
        .data_in        (data_in),
        .fifo_r_enable  (fifo_r_enable),
        .data_from_fifo (data_from_fifo),
        .fifo_full      (fifo_full),
        .fifo_empty     (fifo_empty),
        .crc_err        (crc_err)
    );

    always #3 clk_in  = ~clk_in;
    always #7 clk_out = ~clk_out;

    int n_cmp = 0;
    int n_bad = 0;
    logic [139:0] exp_q[$];
    int model_occ = 0;
    int exp_err = 0;
    int seen_err_cycles = 0;
    bit rd_mode = 1'b0;

    task automatic check(input string name, input logic [139:0] act, input logic [139:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, want);
        end
    endtask

    // CRC-16/CCITT over the bit sequence CTRL, payload[0..len-1], MSB first.
    function automatic logic [15:0] ref_crc(input logic [15:0] ctrl, input logic [15:0] p [8], input int len);
        logic [15:0] crc;
        logic [15:0] w;
        logic        fb;
        crc = 16'hFFFF;
        for (int i = 0; i <= len; i++) begin
            w = (i == 0) ? ctrl : p[i-1];
            for (int b = 15; b >= 0; b--) begin
                fb  = crc[15] ^ w[b];
                crc = crc << 1;
                if (fb) crc = crc ^ 16'h1021;
            end
        end
        return crc;
    endfunction

    function automatic logic [139:0] ref_record(input logic [7:0] mask, input int len, input logic [15:0] p [8]);
        logic [127:0] pl;
        pl = '0;
        for (int k = 0; k < len; k++) pl = (pl << 16) | 128'(p[k]);
        pl = pl << (16 * (8 - len));
        return {mask, 4'(len), pl};
    endfunction

    task automatic send_word(input logic [15:0] w);
        @(negedge clk_in);
        data_in = w;
    endtask

    task automatic idle(input int n);
        logic [15:0] w;
        for (int i = 0; i < n; i++) begin
            w = 16'($urandom);
            if (w == SYNC) w = 16'h0000;
            send_word(w);
        end
    endtask

    task automatic send_frame(input logic [7:0] mask, input int len, input logic [15:0] p [8], input bit corrupt);
        logic [15:0] ctrl;
        logic [15:0] crc;
        ctrl = {mask, 4'($urandom), 4'(len)};
        crc  = ref_crc(ctrl, p, len);
        send_word(SYNC);
        send_word(ctrl);
        for (int k = 0; k < len; k++) send_word(p[k]);
        send_word(corrupt ? (crc ^ 16'h0001) : crc);
        if (corrupt) begin
            exp_err++;
        end else if (model_occ < DEPTH) begin
            exp_q.push_back(ref_record(mask, len, p));
            model_occ++;
        end
    endtask

    task automatic send_bad_len(input logic [3:0] len);
        send_word(SYNC);
        send_word({8'($urandom), 4'($urandom), len});
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 3000) begin
            @(negedge clk_in);
            t++;
        end
        check("drain", 140'(exp_q.size()), 140'd0);
    endtask

    task automatic rand_payload(output logic [15:0] p [8]);
        for (int k = 0; k < 8; k++) p[k] = 16'($urandom);
    endtask

    // Count every clk_in cycle crc_err is high.
    always @(negedge clk_in) begin
        if (rst_n && crc_err === 1'b1) seen_err_cycles++;
    end

    // Read driver and scoreboard monitor in the clk_out domain.
    initial begin : monitor
        bit pending;
        logic [139:0] last;
        pending = 1'b0;
        last = '0;
        forever begin
            @(negedge clk_out);
            if (!rst_n) begin
                pending = 1'b0;
                last = '0;
                fifo_r_enable = 1'b0;
            end else begin
                if (pending) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_read: got %h want no read", data_from_fifo);
                    end else begin
                        check("read_record", data_from_fifo, exp_q.pop_front());
                        model_occ--;
                    end
                    last = data_from_fifo;
                end else begin
                    check("output_hold", data_from_fifo, last);
                end
                fifo_r_enable = rd_mode ? ($urandom_range(0, 3) != 0) : 1'b0;
                pending = fifo_r_enable && !fifo_empty;
            end
        end
    end

    initial begin : main
        logic [15:0] p [8];
        int len;
        rst_n = 1'b0;
        repeat (3) @(negedge clk_in);
        check("reset_crc_err", 140'(crc_err), 140'd0);
        check("reset_full", 140'(fifo_full), 140'd0);
        check("reset_empty", 140'(fifo_empty), 140'd1);
        check("reset_data", data_from_fifo, 140'd0);
        rst_n = 1'b1;
        rd_mode = 1'b1;
        idle(3);

        // Directed good frame and its corrupted twin.
        p = '{16'h1111, 16'h2222, 16'h3333, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
        check("model_record", ref_record(8'h01, 3, p),
              {8'h01, 4'h3, 48'h111122223333, 80'h0});
        send_frame(8'h01, 3, p, 1'b0);
        idle(4);
        wait_drain();
        check("good_no_err", 140'(seen_err_cycles), 140'd0);
        send_frame(8'h01, 3, p, 1'b1);
        idle(20);
        check("bad_crc_pulse", 140'(seen_err_cycles), 140'd1);
        check("bad_crc_empty", 140'(fifo_empty), 140'd1);

        // Garbage before a full-length frame.
        send_word(16'h1234);
        send_word(16'hEB91);
        rand_payload(p);
        send_frame(8'hA5, 8, p, 1'b0);
        idle(4);
        wait_drain();

        // Out-of-range lengths are skipped silently.
        send_bad_len(4'd0);
        send_bad_len(4'd9);
        rand_payload(p);
        send_frame(8'h3C, 5, p, 1'b0);
        idle(4);
        wait_drain();
        check("bad_len_no_err", 140'(seen_err_cycles), 140'(exp_err));

        // Random traffic.
        for (int f = 0; f < 40; f++) begin
            rand_payload(p);
            len = $urandom_range(1, 8);
            if ($urandom_range(0, 7) == 0) send_bad_len(4'($urandom_range(9, 15)));
            send_frame(8'($urandom), len, p, $urandom_range(0, 3) == 0);
            idle($urandom_range(2, 6));
        end
        idle(6);
        wait_drain();
        check("random_err_count", 140'(seen_err_cycles), 140'(exp_err));

        // Overfill with reads off, then drain.
        rd_mode = 1'b0;
        idle(12);
        for (int f = 0; f < 10; f++) begin
            rand_payload(p);
            send_frame(8'($urandom), $urandom_range(1, 8), p, 1'b0);
        end
        idle(6);
        check("full_after_8", 140'(fifo_full), 140'd1);
        check("queued_8", 140'(exp_q.size()), 140'd8);
        rd_mode = 1'b1;
        wait_drain();
        check("empty_after_drain", 140'(fifo_empty), 140'd1);
        idle(12);
        check("not_full_after_drain", 140'(fifo_full), 140'd0);

        // Reset in the middle of a frame.
        send_word(SYNC);
        send_word(16'h7706);
        send_word(16'hAAAA);
        send_word(16'hBBBB);
        rst_n = 1'b0;
        #1;
        check("midreset_crc_err", 140'(crc_err), 140'd0);
        check("midreset_full", 140'(fifo_full), 140'd0);
        check("midreset_empty", 140'(fifo_empty), 140'd1);
        check("midreset_data", data_from_fifo, 140'd0);
        repeat (5) @(negedge clk_in);
        rst_n = 1'b1;
        idle(3);
        rand_payload(p);
        send_frame(8'hC3, 6, p, 1'b0);
        idle(4);
        wait_drain();
        idle(10);
        check("final_err_count", 140'(seen_err_cycles), 140'(exp_err));
        check("final_empty", 140'(fifo_empty), 140'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
